// File: rtl/led_pattern_engine_if.sv
// ---------------------------------------------------------------------------
// led_pattern_engine_if
//   Groups the control inputs and pattern outputs of led_pattern_engine.
//   Clock and reset stay plain ports on the engine itself.
//
//   Signals:
//     S_TOP    [SEL_W-1:0]  speed select (larger = slower step)
//     MODE     [1:0]        00 rotl, 01 rotr, 10 bounce, 11 binary count
//     PAUSE                 1 = hold the pattern, divider keeps running
//     LOUT_TOP [LED_W-1:0]  registered LED pattern
//     STEP                  registered one-cycle pulse per pattern advance
//     DIR_DBG               bounce direction state (0 = LEFT, 1 = RIGHT)
//     DIV_DBG  [DIV_W-1:0]  free-running divider value
//
//   There is no valid/ready handshake: the controls are level inputs sampled
//   every clock, and STEP is a pulse that the consumer may ignore.
// ---------------------------------------------------------------------------
interface led_pattern_engine_if #(
    parameter int LED_W = 8,
    parameter int DIV_W = 26,
    parameter int SEL_W = 3
);
    logic [SEL_W-1:0] S_TOP;
    logic [1:0]       MODE;
    logic             PAUSE;
    logic [LED_W-1:0] LOUT_TOP;
    logic             STEP;
    logic             DIR_DBG;
    logic [DIV_W-1:0] DIV_DBG;

    // Controller side (drives the controls, observes the pattern).
    modport master (
        output S_TOP, MODE, PAUSE,
        input  LOUT_TOP, STEP, DIR_DBG, DIV_DBG
    );

    // Engine side.
    modport slave (
        input  S_TOP, MODE, PAUSE,
        output LOUT_TOP, STEP, DIR_DBG, DIV_DBG
    );
endinterface

// File: rtl/led_pattern_engine.sv
// ---------------------------------------------------------------------------
// led_pattern_engine
//   LED pattern generator running on a single clock. A free-running divider
//   is tapped at bit T = DIV_W - 2**SEL_W + S_TOP; the rising edge of that
//   bit is a one-cycle clock enable (tick) that advances the pattern.
//
//   Ports:
//     CLK_TOP  in   system clock
//     RST_TOP  in   synchronous reset, active-high
//     bus      slave modport of led_pattern_engine_if
//                  (S_TOP, MODE, PAUSE in; LOUT_TOP, STEP, DIR_DBG,
//                   DIV_DBG out)
//
//   All outputs come straight from registers.
// ---------------------------------------------------------------------------
module led_pattern_engine #(
    parameter int LED_W = 8,
    parameter int DIV_W = 26,
    parameter int SEL_W = 3
) (
    input  logic                  CLK_TOP,
    input  logic                  RST_TOP,
    led_pattern_engine_if.slave   bus
);

    localparam int TAP_BASE = DIV_W - 2**SEL_W;
    localparam int IDX_W    = $clog2(DIV_W);

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    logic [DIV_W-1:0] r_div;
    logic             r_tap_q;
    logic [SEL_W-1:0] r_s_q;
    logic [1:0]       r_mode_q;
    logic [LED_W-1:0] r_lout;
    logic             r_step;
    dir_t             r_dir;

    logic [IDX_W-1:0] w_tap_idx;
    logic             w_tap_bit;
    logic             w_tick;
    logic             w_mode_chg;
    logic [LED_W-1:0] w_shl;
    logic [LED_W-1:0] w_shr;
    logic [LED_W-1:0] w_lout_next;
    dir_t             w_dir_next;
    logic             w_step_next;

    function automatic logic [LED_W-1:0] seed_of(input logic [1:0] m);
        return (m == 2'b11) ? '0 : LED_W'(1);
    endfunction

    assign w_tap_idx = IDX_W'(TAP_BASE) + IDX_W'(bus.S_TOP);
    assign w_tap_bit = r_div[w_tap_idx];

    // Rising edge of the tap bit. Blocked on the cycle the speed select moves,
    // because the tap index and tap_q then refer to different bits.
    assign w_tick     = w_tap_bit & ~r_tap_q & (bus.S_TOP == r_s_q);
    assign w_mode_chg = (bus.MODE != r_mode_q);

    assign w_shl = {r_lout[LED_W-2:0], 1'b0};
    assign w_shr = {1'b0, r_lout[LED_W-1:1]};

    // Next-state / output logic. Mode reload beats tick and pause.
    always_comb begin
        w_lout_next = r_lout;
        w_dir_next  = r_dir;
        w_step_next = 1'b0;
        if (w_mode_chg) begin
            w_lout_next = seed_of(bus.MODE);
            w_dir_next  = DIR_LEFT;
        end else if (w_tick && !bus.PAUSE) begin
            w_step_next = 1'b1;
            case (r_mode_q)
                2'b00: w_lout_next = {r_lout[LED_W-2:0], r_lout[LED_W-1]};
                2'b01: w_lout_next = {r_lout[0], r_lout[LED_W-1:1]};
                2'b10: begin
                    if (!$onehot(r_lout)) begin
                        // Recover from a corrupted pattern by restarting.
                        w_lout_next = seed_of(2'b10);
                        w_dir_next  = DIR_LEFT;
                    end else if (r_dir == DIR_LEFT) begin
                        w_lout_next = w_shl;
                        if (w_shl[LED_W-1]) w_dir_next = DIR_RIGHT;
                    end else begin
                        w_lout_next = w_shr;
                        if (w_shr[0]) w_dir_next = DIR_LEFT;
                    end
                end
                default: w_lout_next = r_lout + LED_W'(1);
            endcase
        end
    end

    always_ff @(posedge CLK_TOP) begin
        if (RST_TOP) begin
            r_div    <= '0;
            r_tap_q  <= 1'b0;
            r_s_q    <= bus.S_TOP;
            r_mode_q <= bus.MODE;
            r_lout   <= seed_of(bus.MODE);
            r_dir    <= DIR_LEFT;
            r_step   <= 1'b0;
        end else begin
            r_div    <= r_div + DIV_W'(1);
            r_tap_q  <= w_tap_bit;
            r_s_q    <= bus.S_TOP;
            r_mode_q <= bus.MODE;
            r_lout   <= w_lout_next;
            r_dir    <= w_dir_next;
            r_step   <= w_step_next;
        end
    end

    assign bus.LOUT_TOP = r_lout;
    assign bus.STEP     = r_step;
    assign bus.DIR_DBG  = r_dir;
    assign bus.DIV_DBG  = r_div;

endmodule
